// File: rtl/mem_resp_pkg.sv
// Shared types and geometry for the block-refill/writeback memory responder.
// Block and array geometry are fixed here; the responder takes its defaults from these values.
package mem_resp_pkg;

    localparam int BLOCK_WORDS_DEF = 32;
    localparam int MEM_WORDS_DEF   = 4096;
    localparam int BEAT_BITS       = $clog2(BLOCK_WORDS_DEF);
    localparam int WORD_IDX_BITS   = $clog2(MEM_WORDS_DEF);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        WR_DONE
    } resp_state_t;

    // Word index of the block containing a byte address. Index bits above the array depth are
    // dropped, so addresses alias modulo the array size.
    function automatic logic [WORD_IDX_BITS-1:0] blk_base(input logic [31:0] addr);
        logic [WORD_IDX_BITS-1:0] idx;
        idx = addr[2 +: WORD_IDX_BITS];
        idx[BEAT_BITS-1:0] = '0;
        return idx;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Synchronous word RAM with one write port and one read port; read data appears one cycle after
// rd_en and holds between reads.
module mem_word_array #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset so it maps onto block RAM; only the read register clears.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/mem_block_responder.sv
// Main-memory responder for whole-block refill reads and writeback writes with programmable latency.
// Optional: define MEM_RESP_CRITICAL_WORD_FIRST_EN for critical-word-first reads and rd_first_beat.
module mem_block_responder
    import mem_resp_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
    parameter int MEM_WORDS   = MEM_WORDS_DEF,
    parameter int MEM_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_din,
    output logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  mem_valid,
    output logic                  mem_ack,
    output logic                  mem_busy
`ifdef MEM_RESP_CRITICAL_WORD_FIRST_EN
    ,
    output logic                  rd_first_beat
`endif
);

    localparam int BEAT_W = BEAT_BITS + 1;
    localparam int LAT_W  = $clog2(MEM_LATENCY + 1);

    resp_state_t              state, state_next;
    logic [WORD_IDX_BITS-1:0] base;
    logic [BEAT_W-1:0]        beat;
    logic [LAT_W-1:0]         lat_cnt;
    logic [BEAT_BITS-1:0]     start_off;
    logic [BEAT_BITS-1:0]     rd_off;
    logic                     wr_en, rd_en;
    logic [WORD_IDX_BITS-1:0] wr_addr, rd_addr;

`ifdef MEM_RESP_CRITICAL_WORD_FIRST_EN
    logic first_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            start_off <= '0;
            first_q   <= 1'b0;
        end else begin
            if (state == IDLE && mem_ren && !mem_wen) begin
                start_off <= mem_addr[2 +: BEAT_BITS];
            end
            first_q <= rd_en && (beat == '0);
        end
    end

    assign rd_first_beat = first_q;
`else
    assign start_off = '0;
`endif

    // Reads walk the block from start_off and wrap inside it.
    assign rd_off  = start_off + beat[BEAT_BITS-1:0];
    assign rd_addr = base + WORD_IDX_BITS'(rd_off);

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        wr_addr    = base + WORD_IDX_BITS'(beat[BEAT_BITS-1:0]);
        mem_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_wen) begin
                    wr_en      = 1'b1;
                    wr_addr    = blk_base(mem_addr);
                    state_next = WR_BURST;
                end else if (mem_ren) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_cnt == LAT_W'(MEM_LATENCY - 1)) begin
                    rd_en      = 1'b1;
                    state_next = RD_BURST;
                end
            end
            RD_BURST: begin
                if (beat == BEAT_W'(BLOCK_WORDS)) begin
                    state_next = IDLE;
                end else begin
                    rd_en = 1'b1;
                end
            end
            WR_BURST: begin
                if (mem_wen) begin
                    wr_en = 1'b1;
                    if (beat == BEAT_W'(BLOCK_WORDS - 1)) begin
                        state_next = WR_DONE;
                    end
                end
            end
            WR_DONE: begin
                if (lat_cnt == LAT_W'(MEM_LATENCY)) begin
                    mem_ack    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // A reset cycle must not leave a stray write or read behind.
        if (rst) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            beat      <= '0;
            lat_cnt   <= '0;
            mem_valid <= 1'b0;
        end else begin
            state     <= state_next;
            mem_valid <= rd_en;
            if (state == IDLE) begin
                lat_cnt <= '0;
                beat    <= wr_en ? BEAT_W'(1) : '0;
                if (mem_wen || mem_ren) begin
                    base <= blk_base(mem_addr);
                end
            end else begin
                if (rd_en || wr_en) begin
                    beat <= beat + BEAT_W'(1);
                end
                if (state == RD_WAIT || state == WR_DONE) begin
                    lat_cnt <= lat_cnt + LAT_W'(1);
                end
            end
        end
    end

    assign mem_busy = (state != IDLE) && !mem_ack;

    mem_word_array #(
        .DEPTH (MEM_WORDS),
        .WIDTH (DATA_WIDTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (mem_din),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (mem_dout)
    );

endmodule
